id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_if.sv | 40 ++++
 rtl/id_ex_stage.sv | 63 ++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline register bus: ID-side fields, flush, writeback port, EX-side fields, stall.
// The stage module takes the slave modport; the driver of the ID side takes master.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              valid_id;
  logic [DATA_W-1:0] rd1_id;
  logic [DATA_W-1:0] rd2_id;
  logic [4:0]        rs_id;
  logic [4:0]        rt_id;
  logic [4:0]        rd_id;
  logic [DATA_W-1:0] imm_id;
  logic [7:0]        ctrl_id;
  logic              flush;
  logic              wb_we;
  logic [4:0]        wb_a3;
  logic [DATA_W-1:0] wb_wd;

  logic [DATA_W-1:0] rd1_ex;
  logic [DATA_W-1:0] rd2_ex;
  logic [DATA_W-1:0] imm_ex;
  logic [4:0]        rs_ex;
  logic [4:0]        rt_ex;
  logic [4:0]        rd_ex;
  logic [7:0]        ctrl_ex;
  logic              valid_ex;
  logic              stall_id;

  modport master (
    output valid_id, rd1_id, rd2_id, rs_id, rt_id, rd_id, imm_id, ctrl_id, flush,
    output wb_we, wb_a3, wb_wd,
    input  rd1_ex, rd2_ex, imm_ex, rs_ex, rt_ex, rd_ex, ctrl_ex, valid_ex, stall_id
  );

  modport slave (
    input  valid_id, rd1_id, rd2_id, rs_id, rt_id, rd_id, imm_id, ctrl_id, flush,
    input  wb_we, wb_a3, wb_wd,
    output rd1_ex, rd2_ex, imm_ex, rs_ex, rt_ex, rd_ex, ctrl_ex, valid_ex, stall_id
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and flush bubbles.
// Define ID_EX_WB_BYPASS_EN to forward the writeback port into the captured operands.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);
  logic              ex_reg_write;
  logic              ex_mem_to_reg;
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;

  // ctrl = {reg_write, mem_to_reg, mem_write, alu_src, reg_dst, alu_control[2:0]}
  assign ex_reg_write  = bus.ctrl_ex[7];
  assign ex_mem_to_reg = bus.ctrl_ex[6];

  // Load in EX whose destination is read by ID; the inserted bubble clears valid_ex.
  assign bus.stall_id = bus.valid_id & bus.valid_ex & ex_mem_to_reg & ex_reg_write &
                        (bus.rt_ex != 5'd0) &
                        ((bus.rt_ex == bus.rs_id) | (bus.rt_ex == bus.rt_id));

`ifdef ID_EX_WB_BYPASS_EN
  always_comb begin
    rd1_next = bus.rd1_id;
    rd2_next = bus.rd2_id;
    if (bus.wb_we && (bus.wb_a3 != 5'd0) && (bus.wb_a3 == bus.rs_id)) rd1_next = bus.wb_wd;
    if (bus.wb_we && (bus.wb_a3 != 5'd0) && (bus.wb_a3 == bus.rt_id)) rd2_next = bus.wb_wd;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_we, bus.wb_a3, bus.wb_wd};
  assign rd1_next  = bus.rd1_id;
  assign rd2_next  = bus.rd2_id;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rd1_ex   <= '0;
      bus.rd2_ex   <= '0;
      bus.imm_ex   <= '0;
      bus.rs_ex    <= '0;
      bus.rt_ex    <= '0;
      bus.rd_ex    <= '0;
      bus.ctrl_ex  <= '0;
      bus.valid_ex <= 1'b0;
    end else if (bus.flush || bus.stall_id) begin
      // Bubble: operand and specifier fields keep their last (known) values.
      bus.ctrl_ex  <= '0;
      bus.valid_ex <= 1'b0;
    end else begin
      bus.rd1_ex   <= rd1_next;
      bus.rd2_ex   <= rd2_next;
      bus.imm_ex   <= bus.imm_id;
      bus.rs_ex    <= bus.rs_id;
      bus.rt_ex    <= bus.rt_id;
      bus.rd_ex    <= bus.rd_id;
      bus.ctrl_ex  <= bus.valid_id ? bus.ctrl_id : 8'h00;
      bus.valid_ex <= bus.valid_id;
    end
  end
endmodule
